core_bus_arbiter: RTL and testbench
===================================

// Module: core_bus_arbiter
// PURPOSE
//  Sits directly downstream of the MeMIPS core top level: merges the instruction-fetch port and the
//  data-memory port onto one external SRAM-like bus. One transaction outstanding; data has priority.
//  Instruction fetch is protected from starvation. A response timeout keeps the pipeline from hanging.
// PARAMETERS
//  STARVE_LIMIT  4    consecutive data wins over a pending ifetch before ifetch is forced through
//  TIMEOUT       255  max cycles in WAIT without bus_rvalid before the transaction is aborted
// PORTS
//  clk        in   1   core clock; all state on rising edge
//  rst        in   1   asynchronous, active-high reset
//  if_req     in   1   ifetch read request; held with if_addr until if_gnt
//  if_addr    in   32  ifetch word address
//  if_gnt     out  1   1-cycle pulse: ifetch request accepted
//  if_rvalid  out  1   1-cycle pulse: if_rdata valid
//  if_rdata   out  32  fetched word
//  d_req      in   1   data request; held with d_* until d_gnt
//  d_we       in   1   1 = write, 0 = read
//  d_be       in   4   byte enables (writes)
//  d_addr     in   32  data address
//  d_wdata    in   32  write data
//  d_gnt      out  1   1-cycle pulse: data request accepted
//  d_rvalid   out  1   1-cycle pulse: read data valid / write acknowledged
//  d_rdata    out  32  read data (0 for writes)
//  bus_req    out  1   external request; held with bus_* until bus_gnt
//  bus_we     out  1   external write
//  bus_be     out  4   external byte enables (4'hF for ifetch)
//  bus_addr   out  32  external address
//  bus_wdata  out  32  external write data
//  bus_gnt    in   1   external accept
//  bus_rvalid in   1   external response (read data or write ack)
//  bus_rdata  in   32  external read data
//  err_timeout out 1   1-cycle pulse on abort
// BEHAVIOUR
//  - Reset: every output is 0; state = IDLE; starve_cnt = 0; tmo_cnt = 0; owner = DATA.
//  - Clock and reset are fixed: one clock; asynchronous, active-high reset.
//  - FSM states: IDLE -> REQ -> WAIT -> IDLE.
//  - IDLE: on any request, select a master. Latch its fields into the registered bus_* outputs.
//    Pulse its gnt in the same cycle and go to REQ. With no request, remain in IDLE.
//  - Arbitration when both request: data wins unless starve_cnt == STARVE_LIMIT, in which case ifetch wins.
//  - starve_cnt: +1 when ifetch requests but data wins; cleared on any ifetch grant.
//    Saturates at STARVE_LIMIT.
//  - REQ: bus_req = 1 and bus_* stable until bus_gnt. On bus_gnt: bus_req drops next cycle,
//    tmo_cnt = 0, go to WAIT. No timeout is applied in REQ.
//  - WAIT: tmo_cnt increments each cycle. On bus_rvalid: register bus_rdata (0 if write) into the
//    owner's rdata, pulse the owner's rvalid next cycle, go to IDLE.
//  - If tmo_cnt reaches TIMEOUT (8-bit counter) without bus_rvalid: pulse err_timeout. Pulse the
//    owner's rvalid with rdata = 0. Go to IDLE.
//  - Latency with an immediate bus: request seen cycle 0 (gnt), bus_req cycle 1, bus_gnt cycle 1,
//    bus_rvalid cycle 2, rvalid to master cycle 3. A new grant is possible in cycle 3.
//  - bus_rvalid in IDLE or REQ, or after abort (late response), is ignored. No rvalid, no state change.
//  - A master dropping req before gnt is legal and simply withdraws. After gnt the master must accept
//    exactly one rvalid.
//  - rdata outputs hold their last value between rvalid pulses; gnt and rvalid are never high two
//    cycles in a row.
//  - Reset mid-transaction returns to IDLE immediately and drops bus_req. No rvalid is issued for
//    the lost transaction.
// TESTING
//  1. d_req read @0x100 alone, bus gnt/rvalid immediate, rdata 0x12345678 -> d_gnt c0, bus_req c1,
//     d_rvalid c3 with d_rdata = 0x12345678.
//  2. if_req and d_req held continuously -> grants D,D,D,D,IF,D,D,D,D,IF...; if_gnt every 5th grant.
//  3. d write @0x200 be=4'b0011 wdata 0xAABBCCDD, bus_gnt delayed 3 cycles -> bus_* stable while
//     bus_req=1; d_rvalid with d_rdata = 0.
//  4. No bus_rvalid after gnt -> err_timeout pulse after 255 WAIT cycles; owner rvalid with rdata 0.
//     A later bus_rvalid is ignored.
//  5. rst asserted in WAIT -> all outputs 0 asynchronously. After release, if_req proceeds normally
//     and no stale rvalid appears.

Source files
------------

// File: rtl/core_bus_arbiter_if.sv
// rtl/core_bus_arbiter_if.sv - core ifetch/data ports and external bus of the bus arbiter
// slave is the arbiter's view; master is the core-plus-memory side driving it.
interface core_bus_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        err_timeout;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
               bus_gnt, bus_rvalid, bus_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               bus_req, bus_we, bus_be, bus_addr, bus_wdata, err_timeout
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
               bus_gnt, bus_rvalid, bus_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               bus_req, bus_we, bus_be, bus_addr, bus_wdata, err_timeout
    );
endinterface

// File: rtl/core_bus_arbiter.sv
// rtl/core_bus_arbiter.sv - merges ifetch and data ports onto one external bus
// One transaction in flight, data priority with ifetch starvation guard, response timeout.
module core_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              rst,
    core_bus_arbiter_if.slave bus_if
);
    localparam int unsigned   SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [7:0]    TMO_LAST   = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

    state_e        state_q, state_d;
    logic          owner_if_q, owner_if_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [7:0]    tmo_q, tmo_d;
    logic          we_q, we_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          if_rvalid_q, if_rvalid_d;
    logic          d_rvalid_q, d_rvalid_d;
    logic          err_q, err_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          if_gnt, d_gnt, pick_if;
    logic [31:0]   rsp_data;

    always_comb begin
        state_d     = state_q;
        owner_if_d  = owner_if_q;
        starve_d    = starve_q;
        tmo_d       = tmo_q;
        we_d        = we_q;
        be_d        = be_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        err_d       = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_gnt      = 1'b0;
        d_gnt       = 1'b0;
        rsp_data    = 32'd0;
        pick_if     = bus_if.if_req && (!bus_if.d_req || starve_q == STARVE_MAX);

        case (state_q)
            S_IDLE: begin
                if (pick_if) begin
                    if_gnt     = 1'b1;
                    owner_if_d = 1'b1;
                    we_d       = 1'b0;
                    be_d       = 4'hF;
                    addr_d     = bus_if.if_addr;
                    wdata_d    = 32'd0;
                    starve_d   = '0;
                    state_d    = S_REQ;
                end else if (bus_if.d_req) begin
                    d_gnt      = 1'b1;
                    owner_if_d = 1'b0;
                    we_d       = bus_if.d_we;
                    be_d       = bus_if.d_be;
                    addr_d     = bus_if.d_addr;
                    wdata_d    = bus_if.d_wdata;
                    if (bus_if.if_req && starve_q != STARVE_MAX) starve_d = starve_q + 1'b1;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (bus_if.bus_gnt) begin
                    tmo_d   = 8'd0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A real response and a timeout abort both complete the owner's transaction.
                if (bus_if.bus_rvalid || tmo_q == TMO_LAST) begin
                    rsp_data = (bus_if.bus_rvalid && !we_q) ? bus_if.bus_rdata : 32'd0;
                    err_d    = !bus_if.bus_rvalid;
                    if (owner_if_q) begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = rsp_data;
                    end else begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = rsp_data;
                    end
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_if_q  <= 1'b0;
            starve_q    <= '0;
            tmo_q       <= 8'd0;
            we_q        <= 1'b0;
            be_q        <= 4'h0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            err_q       <= 1'b0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            owner_if_q  <= owner_if_d;
            starve_q    <= starve_d;
            tmo_q       <= tmo_d;
            we_q        <= we_d;
            be_q        <= be_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            err_q       <= err_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    // Grants are combinational from IDLE, so mask them while reset is held.
    assign bus_if.if_gnt      = if_gnt & ~rst;
    assign bus_if.d_gnt       = d_gnt & ~rst;
    assign bus_if.if_rvalid   = if_rvalid_q;
    assign bus_if.if_rdata    = if_rdata_q;
    assign bus_if.d_rvalid    = d_rvalid_q;
    assign bus_if.d_rdata     = d_rdata_q;
    assign bus_if.bus_req     = (state_q == S_REQ);
    assign bus_if.bus_we      = we_q;
    assign bus_if.bus_be      = be_q;
    assign bus_if.bus_addr    = addr_q;
    assign bus_if.bus_wdata   = wdata_q;
    assign bus_if.err_timeout = err_q;
endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb/tb_core_bus_arbiter.sv - self-checking bench for core_bus_arbiter
// Vector table, directed corner sequences, then random traffic against a transaction model.
module tb_core_bus_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;
    logic pend;

    core_bus_arbiter_if ifc ();

    core_bus_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(255)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (ifc.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ifr, dr, we;
        logic [3:0]  be;
        logic [31:0] ia, da, wd, rd;
        logic        exp_if, exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_addr, exp_wd, exp_rd;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic all_zero(input string tag);
        chkb($sformatf("%s if_gnt", tag), ifc.if_gnt, 1'b0);
        chkb($sformatf("%s d_gnt", tag), ifc.d_gnt, 1'b0);
        chkb($sformatf("%s if_rvalid", tag), ifc.if_rvalid, 1'b0);
        chkb($sformatf("%s d_rvalid", tag), ifc.d_rvalid, 1'b0);
        chk($sformatf("%s if_rdata", tag), ifc.if_rdata, 32'h0);
        chk($sformatf("%s d_rdata", tag), ifc.d_rdata, 32'h0);
        chkb($sformatf("%s bus_req", tag), ifc.bus_req, 1'b0);
        chkb($sformatf("%s bus_we", tag), ifc.bus_we, 1'b0);
        chk($sformatf("%s bus_be", tag), 32'(ifc.bus_be), 32'h0);
        chk($sformatf("%s bus_addr", tag), ifc.bus_addr, 32'h0);
        chk($sformatf("%s bus_wdata", tag), ifc.bus_wdata, 32'h0);
        chkb($sformatf("%s err_timeout", tag), ifc.err_timeout, 1'b0);
    endtask

    // Immediate bus: gnt in cycle 0, bus_req/bus_gnt cycle 1, bus_rvalid cycle 2, rvalid cycle 3.
    task automatic run_vec(input vec_t v, input int idx);
        ifc.if_req = v.ifr; ifc.if_addr = v.ia;
        ifc.d_req = v.dr; ifc.d_we = v.we; ifc.d_be = v.be; ifc.d_addr = v.da; ifc.d_wdata = v.wd;
        smp();
        chkb($sformatf("v%0d if_gnt", idx), ifc.if_gnt, v.exp_if);
        chkb($sformatf("v%0d d_gnt", idx), ifc.d_gnt, !v.exp_if);
        chkb($sformatf("v%0d bus_req c0", idx), ifc.bus_req, 1'b0);
        tick();
        ifc.if_req = 1'b0; ifc.d_req = 1'b0; ifc.bus_gnt = 1'b1;
        smp();
        chkb($sformatf("v%0d bus_req c1", idx), ifc.bus_req, 1'b1);
        chkb($sformatf("v%0d bus_we", idx), ifc.bus_we, v.exp_we);
        chk($sformatf("v%0d bus_be", idx), 32'(ifc.bus_be), 32'(v.exp_be));
        chk($sformatf("v%0d bus_addr", idx), ifc.bus_addr, v.exp_addr);
        chk($sformatf("v%0d bus_wdata", idx), ifc.bus_wdata, v.exp_wd);
        tick();
        ifc.bus_gnt = 1'b0; ifc.bus_rvalid = 1'b1; ifc.bus_rdata = v.rd;
        smp();
        chkb($sformatf("v%0d bus_req c2", idx), ifc.bus_req, 1'b0);
        chkb($sformatf("v%0d early rvalid", idx), ifc.if_rvalid | ifc.d_rvalid, 1'b0);
        tick();
        ifc.bus_rvalid = 1'b0;
        smp();
        chkb($sformatf("v%0d if_rvalid", idx), ifc.if_rvalid, v.exp_if);
        chkb($sformatf("v%0d d_rvalid", idx), ifc.d_rvalid, !v.exp_if);
        chk($sformatf("v%0d rdata", idx), v.exp_if ? ifc.if_rdata : ifc.d_rdata, v.exp_rd);
        tick();
    endtask

    // Always-accepting bus that answers one cycle after the accept.
    task automatic bus_step(output logic ig, output logic dg);
        ifc.bus_gnt    = ifc.bus_req;
        ifc.bus_rvalid = pend;
        ifc.bus_rdata  = 32'hA500_0000 | ($urandom & 32'hFFFF);
        smp();
        ig = ifc.if_gnt;
        dg = ifc.d_gnt;
        pend = ifc.bus_req && ifc.bus_gnt;
        tick();
    endtask

    // Transaction-level reference state for the random phase
    int          starve;
    int          phase;          // 0 free, 1 waiting for bus accept, 2 waiting for bus response
    logic        t_if, t_we;
    logic [3:0]  t_be;
    logic [31:0] t_addr, t_wd;
    logic        exp_rv_if, exp_rv_d;
    logic [31:0] mdl_if_rd, mdl_d_rd;

    initial begin
        logic ig, dg, last_ig, last_dg, e_ig, e_dg;
        int   g;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 4'hF, 32'h0,  32'h100, 32'h0,        32'h12345678,
                    1'b0, 1'b0, 4'hF, 32'h100, 32'h0,        32'h12345678};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 4'h3, 32'h40, 32'h0,   32'hFFFFFFFF, 32'hCAFEF00D,
                    1'b1, 1'b0, 4'hF, 32'h40,  32'h0,        32'hCAFEF00D};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 4'h3, 32'h0,  32'h200, 32'hAABBCCDD, 32'hDEADBEEF,
                    1'b0, 1'b1, 4'h3, 32'h200, 32'hAABBCCDD, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h44, 32'h300, 32'h0,        32'h55AA55AA,
                    1'b0, 1'b0, 4'hF, 32'h300, 32'h0,        32'h55AA55AA};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 4'hF, 32'h44, 32'h0,   32'h0,        32'h11112222,
                    1'b1, 1'b0, 4'hF, 32'h44,  32'h0,        32'h11112222};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 4'hC, 32'h48, 32'h304, 32'h01020304, 32'h77777777,
                    1'b0, 1'b1, 4'hC, 32'h304, 32'h01020304, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 4'hF, 32'h4C, 32'h0,   32'h0,        32'h00000009,
                    1'b1, 1'b0, 4'hF, 32'h4C,  32'h0,        32'h00000009};

        rst = 1'b1;
        ifc.if_req = 1'b0; ifc.if_addr = 32'h0;
        ifc.d_req = 1'b0; ifc.d_we = 1'b0; ifc.d_be = 4'h0; ifc.d_addr = 32'h0; ifc.d_wdata = 32'h0;
        ifc.bus_gnt = 1'b0; ifc.bus_rvalid = 1'b0; ifc.bus_rdata = 32'h0;
        pend = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        smp();
        all_zero("reset");
        tick();
        rst = 1'b0;
        smp();
        all_zero("post-reset");
        tick();

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Write with bus_gnt held off three cycles; request fields change after gnt
        ifc.d_req = 1'b1; ifc.d_we = 1'b1; ifc.d_be = 4'b0011; ifc.d_addr = 32'h200; ifc.d_wdata = 32'hAABBCCDD;
        smp();
        chkb("wr d_gnt", ifc.d_gnt, 1'b1);
        tick();
        ifc.d_req = 1'b0; ifc.d_be = 4'hF; ifc.d_addr = 32'hFFFFFFFF; ifc.d_wdata = 32'h0;
        for (int c = 1; c <= 4; c++) begin
            ifc.bus_gnt = (c == 4);
            smp();
            chkb($sformatf("wr c%0d bus_req", c), ifc.bus_req, 1'b1);
            chkb($sformatf("wr c%0d bus_we", c), ifc.bus_we, 1'b1);
            chk($sformatf("wr c%0d bus_be", c), 32'(ifc.bus_be), 32'h3);
            chk($sformatf("wr c%0d bus_addr", c), ifc.bus_addr, 32'h200);
            chk($sformatf("wr c%0d bus_wdata", c), ifc.bus_wdata, 32'hAABBCCDD);
            tick();
        end
        ifc.bus_gnt = 1'b0; ifc.bus_rvalid = 1'b1; ifc.bus_rdata = 32'h99999999;
        smp();
        chkb("wr bus_req dropped", ifc.bus_req, 1'b0);
        chkb("wr early d_rvalid", ifc.d_rvalid, 1'b0);
        tick();
        ifc.bus_rvalid = 1'b0;
        smp();
        chkb("wr d_rvalid", ifc.d_rvalid, 1'b1);
        chk("wr d_rdata", ifc.d_rdata, 32'h0);
        tick();

        // Both masters held: ifetch forced through every fifth grant
        ifc.if_req = 1'b1; ifc.if_addr = 32'h1000;
        ifc.d_req = 1'b1; ifc.d_we = 1'b0; ifc.d_be = 4'hF; ifc.d_addr = 32'h2000;
        g = 0;
        for (int c = 0; c < 200 && g < 10; c++) begin
            bus_step(ig, dg);
            if (ig || dg) begin
                chkb($sformatf("starve grant %0d is ifetch", g), ig, (g % 5 == 4));
                g++;
            end
        end
        chk("starve grant count", 32'(g), 32'd10);
        ifc.if_req = 1'b0; ifc.d_req = 1'b0;
        repeat (4) bus_step(ig, dg);
        ifc.bus_gnt = 1'b0; ifc.bus_rvalid = 1'b0;

        // Timeout: ifetch accepted, bus never responds
        ifc.if_req = 1'b1; ifc.if_addr = 32'h80;
        smp();
        chkb("tmo if_gnt", ifc.if_gnt, 1'b1);
        tick();
        ifc.if_req = 1'b0; ifc.bus_gnt = 1'b1;
        smp();
        chkb("tmo bus_req", ifc.bus_req, 1'b1);
        tick();
        ifc.bus_gnt = 1'b0;
        for (int k = 0; k < 255; k++) begin
            smp();
            chkb($sformatf("tmo quiet wait %0d", k), ifc.err_timeout | ifc.if_rvalid, 1'b0);
            tick();
        end
        smp();
        chkb("tmo err_timeout", ifc.err_timeout, 1'b1);
        chkb("tmo if_rvalid", ifc.if_rvalid, 1'b1);
        chk("tmo if_rdata", ifc.if_rdata, 32'h0);
        tick();
        ifc.bus_rvalid = 1'b1; ifc.bus_rdata = 32'hBAD0BAD0;
        smp();
        chkb("tmo err one cycle", ifc.err_timeout, 1'b0);
        chkb("tmo rvalid one cycle", ifc.if_rvalid, 1'b0);
        tick();
        ifc.bus_rvalid = 1'b0;
        smp();
        chkb("late rsp if_rvalid", ifc.if_rvalid | ifc.d_rvalid, 1'b0);
        chk("late rsp if_rdata", ifc.if_rdata, 32'h0);
        chkb("late rsp bus_req", ifc.bus_req, 1'b0);
        tick();

        // Reset asserted while waiting for a response
        ifc.d_req = 1'b1; ifc.d_we = 1'b0; ifc.d_addr = 32'h400;
        smp();
        chkb("rst d_gnt", ifc.d_gnt, 1'b1);
        tick();
        ifc.d_req = 1'b0; ifc.bus_gnt = 1'b1;
        tick();
        ifc.bus_gnt = 1'b0; ifc.if_req = 1'b1; ifc.if_addr = 32'h500;
        #1 rst = 1'b1;
        #1 all_zero("async rst");
        tick();
        ifc.bus_rvalid = 1'b1; ifc.bus_rdata = 32'hDEADDEAD;
        #2 rst = 1'b0;
        smp();
        chkb("post-rst if_gnt", ifc.if_gnt, 1'b1);
        chkb("post-rst no stale rvalid", ifc.if_rvalid | ifc.d_rvalid, 1'b0);
        tick();
        ifc.if_req = 1'b0; ifc.bus_gnt = 1'b1; ifc.bus_rvalid = 1'b1; ifc.bus_rdata = 32'hDEAD0001;
        smp();
        chkb("post-rst bus_req", ifc.bus_req, 1'b1);
        chk("post-rst bus_addr", ifc.bus_addr, 32'h500);
        chkb("post-rst rvalid in req", ifc.if_rvalid | ifc.d_rvalid, 1'b0);
        tick();
        ifc.bus_gnt = 1'b0; ifc.bus_rdata = 32'h13572468;
        smp();
        chkb("post-rst wait rvalid", ifc.if_rvalid | ifc.d_rvalid, 1'b0);
        tick();
        ifc.bus_rvalid = 1'b0;
        smp();
        chkb("post-rst if_rvalid", ifc.if_rvalid, 1'b1);
        chk("post-rst if_rdata", ifc.if_rdata, 32'h13572468);
        chkb("post-rst d_rvalid", ifc.d_rvalid, 1'b0);
        tick();

        // Random traffic against the transaction-level model
        starve = 0; phase = 0; exp_rv_if = 1'b0; exp_rv_d = 1'b0;
        mdl_if_rd = 32'h13572468; mdl_d_rd = 32'h0;
        last_ig = 1'b0; last_dg = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (ifc.if_req && last_ig) ifc.if_req = 1'b0;
            else if (ifc.if_req) begin
                if ($urandom_range(15) == 0) ifc.if_req = 1'b0;
            end else if ($urandom_range(2) == 0) begin
                ifc.if_req = 1'b1; ifc.if_addr = $urandom;
            end
            if (ifc.d_req && last_dg) ifc.d_req = 1'b0;
            else if (ifc.d_req) begin
                if ($urandom_range(15) == 0) ifc.d_req = 1'b0;
            end else if ($urandom_range(2) == 0) begin
                ifc.d_req = 1'b1; ifc.d_we = 1'($urandom_range(1)); ifc.d_be = 4'($urandom_range(15));
                ifc.d_addr = $urandom; ifc.d_wdata = $urandom;
            end
            ifc.bus_gnt    = ifc.bus_req && ($urandom_range(2) != 0);
            ifc.bus_rvalid = ($urandom_range(2) == 0);
            ifc.bus_rdata  = $urandom;
            smp();

            e_ig = (phase == 0) && ifc.if_req && (!ifc.d_req || starve >= 4);
            e_dg = (phase == 0) && ifc.d_req && !e_ig;
            chkb("rnd if_gnt", ifc.if_gnt, e_ig);
            chkb("rnd d_gnt", ifc.d_gnt, e_dg);
            chkb("rnd if_rvalid", ifc.if_rvalid, exp_rv_if);
            chkb("rnd d_rvalid", ifc.d_rvalid, exp_rv_d);
            chk("rnd if_rdata", ifc.if_rdata, mdl_if_rd);
            chk("rnd d_rdata", ifc.d_rdata, mdl_d_rd);
            chkb("rnd err_timeout", ifc.err_timeout, 1'b0);
            chkb("rnd bus_req", ifc.bus_req, phase == 1);
            if (phase == 1) begin
                chk("rnd bus fields", {ifc.bus_addr[27:0], ifc.bus_be}, {t_addr[27:0], t_be});
                chk("rnd bus_wdata", ifc.bus_wdata, t_wd);
                chkb("rnd bus_we", ifc.bus_we, t_we);
            end
            last_ig = ifc.if_gnt;
            last_dg = ifc.d_gnt;

            exp_rv_if = 1'b0;
            exp_rv_d  = 1'b0;
            if (phase == 2 && ifc.bus_rvalid) begin
                if (t_if) begin
                    exp_rv_if = 1'b1; mdl_if_rd = t_we ? 32'h0 : ifc.bus_rdata;
                end else begin
                    exp_rv_d = 1'b1; mdl_d_rd = t_we ? 32'h0 : ifc.bus_rdata;
                end
                phase = 0;
            end else if (phase == 1 && ifc.bus_gnt) begin
                phase = 2;
            end else if (e_ig) begin
                phase = 1; t_if = 1'b1; t_we = 1'b0; t_be = 4'hF; t_addr = ifc.if_addr; t_wd = 32'h0;
                starve = 0;
            end else if (e_dg) begin
                phase = 1; t_if = 1'b0; t_we = ifc.d_we; t_be = ifc.d_be; t_addr = ifc.d_addr;
                t_wd = ifc.d_wdata;
                if (ifc.if_req && starve < 4) starve++;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
